// File: rtl/uart_ctrl_pkg.sv
// Shared constants and FSM state type for the memory-mapped UART controller.
package uart_ctrl_pkg;

  // Register word index, taken from cpud_addr[3:2]
  localparam logic [1:0] REG_DATA     = 2'd0;
  localparam logic [1:0] REG_STATUS   = 2'd1;
  localparam logic [1:0] REG_BAUD_DIV = 2'd2;
  localparam logic [1:0] REG_IRQ_EN   = 2'd3;

  localparam int unsigned ST_RX_NOT_EMPTY = 16;
  localparam int unsigned ST_TX_IDLE      = 17;
  localparam int unsigned ST_RX_OVF       = 18;
  localparam int unsigned ST_TX_OVF       = 19;
  localparam int unsigned ST_FRAME_ERR    = 20;

  localparam int unsigned IE_RX_NOT_EMPTY = 0;
  localparam int unsigned IE_TX_EMPTY     = 1;
  localparam int unsigned IE_ERR          = 2;

  localparam int unsigned BAUD_MIN = 4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with read-first head output; push into a full FIFO succeeds when popped in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       head_c_o,
  output logic                   not_empty_o,
  output logic [$clog2(DEPTH):0] slots_free_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    free_q, free_d;
  logic             not_empty_q, not_empty_d;
  logic             do_rd, do_wr;

  always_comb begin
    do_rd       = rd_en_i && not_empty_q;
    do_wr       = wr_en_i && ((free_q != '0) || do_rd);
    wr_ptr_d    = wr_ptr_q + AW'(do_wr);
    rd_ptr_d    = rd_ptr_q + AW'(do_rd);
    free_d      = free_q - CW'(do_wr) + CW'(do_rd);
    not_empty_d = free_d != CW'(DEPTH);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      free_q      <= CW'(DEPTH);
      not_empty_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      free_q      <= free_d;
      not_empty_q <= not_empty_d;
    end
  end

  // Storage needs no reset; pointers define validity
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_c_o     = mem_q[rd_ptr_q];
  assign not_empty_o  = not_empty_q;
  assign slots_free_o = free_q;

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped UART: register window, TX/RX FIFOs, baud-timed TX shifter and mid-bit RX sampler.
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DEFAULT_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpud_request,
  input  logic [15:0] cpud_addr,
  input  logic        cpud_write,
  input  logic [3:0]  cpud_byte_enable,
  input  logic [31:0] cpud_wdata,
  output logic [31:0] cpud_rdata,
  output logic        cpud_ack,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        irq
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0] baud_div_q, baud_div_d, new_div;
  logic [2:0]  irq_en_q, irq_en_d, w1c, irq_vec;
  logic        rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, frame_err_q, frame_err_d;
  logic [31:0] rdata_q, rdata_d, status_c;
  logic        ack_q, irq_q, irq_d;
  logic        mapped_c, wr_c, rd_c, tx_drop_c;
  logic [1:0]  reg_idx;

  logic          tx_push_c, tx_pop_c, tx_ne, rx_push_c, rx_pop_c, rx_ne;
  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_free, rx_free;

  uart_state_t tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic        uart_tx_q, uart_tx_d, tx_bit_end_c, rx_bit_end_c, rx_half_c;
  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  logic        rx_stop_c, rx_ovf_set_c, frame_err_set_c;
  logic        unused_c;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clock(clock), .reset(reset), .wr_en_i(tx_push_c), .wr_data_i(cpud_wdata[7:0]),
    .rd_en_i(tx_pop_c), .head_c_o(tx_head), .not_empty_o(tx_ne), .slots_free_o(tx_free)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clock(clock), .reset(reset), .wr_en_i(rx_push_c), .wr_data_i(rx_shift_q),
    .rd_en_i(rx_pop_c), .head_c_o(rx_head), .not_empty_o(rx_ne), .slots_free_o(rx_free)
  );

  // Register file: decode, sticky flags, read mux and interrupt
  always_comb begin
    mapped_c  = cpud_addr[15:4] == 12'd0;
    reg_idx   = cpud_addr[3:2];
    wr_c      = cpud_request && cpud_write && mapped_c;
    rd_c      = cpud_request && !cpud_write && mapped_c;
    tx_push_c = wr_c && (reg_idx == REG_DATA) && cpud_byte_enable[0];
    rx_pop_c  = rd_c && (reg_idx == REG_DATA) && rx_ne;
    tx_drop_c = tx_push_c && (tx_free == '0) && !tx_pop_c;
    w1c       = (wr_c && (reg_idx == REG_STATUS) && cpud_byte_enable[2]) ? cpud_wdata[20:18] : 3'b000;

    new_div    = {cpud_byte_enable[1] ? cpud_wdata[15:8] : baud_div_q[15:8],
                  cpud_byte_enable[0] ? cpud_wdata[7:0]  : baud_div_q[7:0]};
    baud_div_d = baud_div_q;
    if (wr_c && (reg_idx == REG_BAUD_DIV) && (|cpud_byte_enable[1:0]))
      baud_div_d = (new_div < 16'(BAUD_MIN)) ? 16'(BAUD_MIN) : new_div;
    irq_en_d = irq_en_q;
    if (wr_c && (reg_idx == REG_IRQ_EN) && cpud_byte_enable[0]) irq_en_d = cpud_wdata[2:0];

    // A set in the same cycle as its W1C clear wins
    rx_ovf_d    = rx_ovf_set_c    | (rx_ovf_q    & ~w1c[0]);
    tx_ovf_d    = tx_drop_c       | (tx_ovf_q    & ~w1c[1]);
    frame_err_d = frame_err_set_c | (frame_err_q & ~w1c[2]);

    status_c                  = 32'(tx_free);
    status_c[ST_RX_NOT_EMPTY] = rx_ne;
    status_c[ST_TX_IDLE]      = !tx_ne && (tx_state_q == IDLE);
    status_c[ST_RX_OVF]       = rx_ovf_q;
    status_c[ST_TX_OVF]       = tx_ovf_q;
    status_c[ST_FRAME_ERR]    = frame_err_q;

    rdata_d = '0;
    if (rd_c) begin
      case (reg_idx)
        REG_DATA:     rdata_d = rx_ne ? {24'd0, rx_head} : 32'hFFFF_FFFF;
        REG_STATUS:   rdata_d = status_c;
        REG_BAUD_DIV: rdata_d = {16'd0, baud_div_q};
        default:      rdata_d = {29'd0, irq_en_q};
      endcase
    end

    irq_vec                  = '0;
    irq_vec[IE_RX_NOT_EMPTY] = rx_ne;
    irq_vec[IE_TX_EMPTY]     = !tx_ne;
    irq_vec[IE_ERR]          = rx_ovf_q | tx_ovf_q | frame_err_q;
    irq_d                    = |(irq_en_q & irq_vec);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      baud_div_q  <= 16'(DEFAULT_DIV);
      irq_en_q    <= '0;
      rx_ovf_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      baud_div_q  <= baud_div_d;
      irq_en_q    <= irq_en_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_ovf_q    <= tx_ovf_d;
      frame_err_q <= frame_err_d;
      rdata_q     <= rdata_d;
      ack_q       <= cpud_request;
      irq_q       <= irq_d;
    end
  end

  // TX FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= 16'(DEFAULT_DIV);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      uart_tx_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

  assign tx_bit_end_c = tx_cnt_q == (tx_div_q - 16'd1);

  // TX FSM: next state; divisor is latched whenever a frame starts
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + 16'd1;
    tx_div_d   = tx_div_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    case (tx_state_q)
      IDLE: begin
        tx_cnt_d = '0;
        if (tx_ne) begin
          tx_state_d = START;
          tx_div_d   = baud_div_q;
          tx_shift_d = tx_head;
        end
      end
      START: if (tx_bit_end_c) begin
        tx_state_d = DATA;
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
      end
      DATA: if (tx_bit_end_c) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_state_d = STOP;
        end else begin
          tx_bit_d   = tx_bit_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end
      default: if (tx_bit_end_c) begin
        tx_cnt_d = '0;
        if (tx_ne) begin
          tx_state_d = START;
          tx_div_d   = baud_div_q;
          tx_shift_d = tx_head;
        end else begin
          tx_state_d = IDLE;
        end
      end
    endcase
  end

  // TX FSM: outputs; line level follows the next state so it is registered alongside it
  always_comb begin
    tx_pop_c = tx_ne && ((tx_state_q == IDLE) || ((tx_state_q == STOP) && tx_bit_end_c));
    case (tx_state_d)
      START:   uart_tx_d = 1'b0;
      DATA:    uart_tx_d = tx_shift_d[0];
      default: uart_tx_d = 1'b1;
    endcase
  end

  // RX synchroniser and edge history
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // RX FSM: state register
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= 16'(DEFAULT_DIV);
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  assign rx_bit_end_c = rx_cnt_q == (rx_div_q - 16'd1);
  assign rx_half_c    = rx_cnt_q == ({1'b0, rx_div_q[15:1]} - 16'd1);

  // RX FSM: next state; START checks mid start bit, later samples are one bit apart
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 16'd1;
    rx_div_d   = rx_div_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    case (rx_state_q)
      IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = START;
          rx_div_d   = baud_div_q;
        end
      end
      START: if (rx_half_c) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_sync_q ? IDLE : DATA;
      end
      DATA: if (rx_bit_end_c) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = STOP;
        else rx_bit_d = rx_bit_q + 3'd1;
      end
      default: if (rx_bit_end_c) begin
        rx_cnt_d   = '0;
        rx_state_d = IDLE;
      end
    endcase
  end

  // RX FSM: outputs at the stop-bit sample
  always_comb begin
    rx_stop_c       = (rx_state_q == STOP) && rx_bit_end_c;
    rx_push_c       = rx_stop_c && rx_sync_q;
    frame_err_set_c = rx_stop_c && !rx_sync_q;
    rx_ovf_set_c    = rx_push_c && (rx_free == '0) && !rx_pop_c;
  end

  assign unused_c   = ^{cpud_wdata[31:21], cpud_wdata[17:16], cpud_byte_enable[3]};
  assign cpud_rdata = rdata_q;
  assign cpud_ack   = ack_q;
  assign uart_tx    = uart_tx_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl: registers, TX framing, loopback RX, errors, reset.
module tb_uart_ctrl;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DEF_DIV = 434;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpud_request;
  logic [15:0] cpud_addr;
  logic        cpud_write;
  logic [3:0]  cpud_byte_enable;
  logic [31:0] cpud_wdata;
  logic [31:0] cpud_rdata;
  logic        cpud_ack;
  logic        uart_tx;
  logic        uart_rx;
  logic        irq;
  logic        loop_en;
  logic        rx_drv;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;
  assign uart_rx = loop_en ? uart_tx : rx_drv;

  uart_ctrl #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
    .clock(clock), .reset(reset), .cpud_request(cpud_request), .cpud_addr(cpud_addr),
    .cpud_write(cpud_write), .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata),
    .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack), .uart_tx(uart_tx), .uart_rx(uart_rx), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clock);
    cpud_request = 1'b1; cpud_write = 1'b1; cpud_addr = addr;
    cpud_wdata = data; cpud_byte_enable = be;
    @(negedge clock);
    cpud_request = 1'b0; cpud_write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    @(negedge clock);
    cpud_request = 1'b1; cpud_write = 1'b0; cpud_addr = addr;
    @(negedge clock);
    cpud_request = 1'b0;
    check({tag, "_ack"}, 32'(cpud_ack), 32'd1);
    check(tag, cpud_rdata, exp);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] frame;
    int         good;
    logic       found, seen, prev_irq;

    reset = 1'b1; cpud_request = 1'b0; cpud_addr = '0; cpud_write = 1'b0;
    cpud_byte_enable = '0; cpud_wdata = '0; loop_en = 1'b0; rx_drv = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(cpud_ack), 32'd0);
    reset = 1'b0;

    // Reset values of all registers, plus unmapped read
    read_check("rst_data", 16'h0000, 32'hFFFF_FFFF);
    @(negedge clock);
    check("rdata_no_ack", cpud_rdata, 32'd0);
    read_check("rst_status", 16'h0004, 32'h0002_0000 | 32'(DEPTH));
    read_check("rst_baud", 16'h0008, 32'(DEF_DIV));
    read_check("rst_irq_en", 16'h000C, 32'd0);
    read_check("unmapped", 16'h0014, 32'd0);

    // TX framing of 0x55 at 8 clocks per bit
    bus_write(16'h0008, 32'd8, 4'h3);
    bus_write(16'h0000, 32'h55, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (uart_tx == 1'b0) found = 1'b1;
      else @(negedge clock);
    end
    check("tx_start_seen", 32'(found), 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int b = 0; b < 10; b++) begin
      good = 0;
      for (int c = 0; c < 8; c++) begin
        if (uart_tx === frame[b]) good++;
        @(negedge clock);
      end
      check($sformatf("tx_bit%0d", b), 32'(good), 32'd8);
    end
    check("tx_line_after", 32'(uart_tx), 32'd1);
    read_check("tx_idle_status", 16'h0004, 32'h0002_0010);

    // Loopback of two back-to-back frames
    loop_en = 1'b1;
    bus_write(16'h0000, 32'hA5, 4'h1);
    bus_write(16'h0000, 32'h3C, 4'h1);
    repeat (220) @(negedge clock);
    read_check("rx_byte0", 16'h0000, 32'h0000_00A5);
    read_check("rx_byte1", 16'h0000, 32'h0000_003C);
    read_check("rx_empty", 16'h0000, 32'hFFFF_FFFF);
    loop_en = 1'b0;

    // Frame with low stop bit; STATUS polled every cycle to time irq against the flag
    bus_write(16'h000C, 32'd4, 4'h1);
    frame = {1'b0, 8'h5A, 1'b0};
    seen = 1'b0; prev_irq = irq;
    @(negedge clock);
    cpud_request = 1'b1; cpud_write = 1'b0; cpud_addr = 16'h0004;
    fork
      begin
        for (int b = 0; b < 10; b++) begin
          rx_drv = frame[b];
          repeat (8) @(negedge clock);
        end
        rx_drv = 1'b1;
      end
      begin
        for (int i = 0; i < 120; i++) begin
          @(negedge clock);
          if (!seen && cpud_ack && cpud_rdata[20]) begin
            seen = 1'b1;
            check("irq_low_before_flag", 32'(prev_irq), 32'd0);
            check("irq_high_after_flag", 32'(irq), 32'd1);
          end
          prev_irq = irq;
        end
      end
    join
    cpud_request = 1'b0;
    check("frame_err_seen", 32'(seen), 32'd1);
    read_check("fe_status", 16'h0004, 32'h0012_0010);
    bus_write(16'h0004, 32'h0010_0000, 4'hF);
    read_check("fe_cleared", 16'h0004, 32'h0002_0010);
    check("irq_dropped", 32'(irq), 32'd0);
    bus_write(16'h000C, 32'd0, 4'h1);

    // TX overflow with a slow divisor, then W1C
    bus_write(16'h0008, 32'd1000, 4'h3);
    for (int i = 0; i < int'(DEPTH) + 2; i++) bus_write(16'h0000, 32'(i + 1), 4'h1);
    read_check("ovf_status", 16'h0004, 32'h0008_0000);
    bus_write(16'h0004, 32'h0008_0000, 4'hF);
    read_check("ovf_cleared", 16'h0004, 32'h0000_0000);

    // Divisor floor, then reset in the middle of a frame
    bus_write(16'h0008, 32'd2, 4'h3);
    read_check("baud_floor", 16'h0008, 32'd4);
    bus_write(16'h000C, 32'd7, 4'h1);
    read_check("irq_en_rw", 16'h000C, 32'd7);
    check("tx_mid_frame", 32'(uart_tx), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_tx", 32'(uart_tx), 32'd1);
    reset = 1'b0;
    read_check("post_rst_status", 16'h0004, 32'h0002_0000 | 32'(DEPTH));
    read_check("post_rst_baud", 16'h0008, 32'(DEF_DIV));
    read_check("post_rst_irq_en", 16'h000C, 32'd0);
    repeat (20) @(negedge clock);
    check("post_rst_line", 32'(uart_tx), 32'd1);
    check("post_rst_irq", 32'(irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Parametrised memory-mapped UART controller on the CPU data bus, second-generation serial port for the hardware register space. It adds a programmable baud divisor, configurable FIFO depth, sticky error flags and a maskable interrupt to the basic TX/RX FIFO port. The block owns its own baud timing, TX shifter and RX sampler, and decodes a 16-byte register window placed by the top-level address decoder.

## Interface
- FIFO_DEPTH, 16, entries per TX and RX FIFO; power of two, 4..1024.
- DEFAULT_DIV, 434, reset value of BAUD_DIV in clocks per bit (50 MHz / 115200).
- clock  input  1  clock; all state on posedge.
- reset  input  1  reset, synchronous, active-high.
- cpud_request  input  1  one-cycle bus request strobe.
- cpud_addr  input  16  byte address within window; only [3:2] decoded, [15:4] must be 0 else unmapped.
- cpud_write  input  1  1 = write, 0 = read.
- cpud_byte_enable  input  4  write byte lanes.
- cpud_wdata  input  32  write data.
- cpud_rdata  output  32  read data, valid with ack, 0 otherwise; reset 0.
- cpud_ack  output  1  response strobe; reset 0.
- uart_tx  output  1  serial out, idle high; reset 1.
- uart_rx  input  1  serial in, asynchronous.
- irq  output  1  level interrupt, registered; reset 0.

## Operation
- 0x0 DATA: write lane0 pushes wdata[7:0] to TX FIFO; if full, byte dropped and TX_OVF set. Read pops RX FIFO, returns {24'b0, byte}; 0xFFFFFFFF if empty (no pop).
- 0x4 STATUS (R, W1C on [20:18]): [15:0] TX slots free; [16] RX not empty; [17] TX idle (FIFO empty and shifter IDLE); [18] RX_OVF; [19] TX_OVF; [20] FRAME_ERR.
- 0x8 BAUD_DIV (R/W, lanes 0-1): 16-bit clocks per bit; written values below 4 stored as 4.
- 0xC IRQ_EN (R/W, lane0): [0] RX not empty, [1] TX FIFO empty, [2] any sticky error.
- Unmapped read returns 0; unmapped write ignored; both still acked.
- irq next cycle = |(IRQ_EN & {err, tx_empty, rx_not_empty}).
- TX FSM IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE. Leaves IDLE when TX FIFO not empty, popping head in same cycle; divisor latched at frame start; each state held BAUD_DIV clocks; STOP returns to IDLE (or straight to START if FIFO non-empty, no gap).
- RX: 2-flop synchroniser. FSM IDLE -> START on synchronised falling edge; sample at BAUD_DIV/2 (integer division); if high, abort to IDLE. DATA samples at mid-bit 8 times, STOP samples mid-bit. Stop low: byte discarded, FRAME_ERR set. Stop high and RX FIFO full: byte discarded, RX_OVF set. Else push. Return to IDLE after STOP sample (half-bit early, allows back-to-back frames).

## Timing
- cpud_ack one cycle after cpud_request, every request, back-to-back requests allowed.
- Reads return state sampled in the request cycle; DATA pop occurs in request cycle.
- Register writes visible to reads issued the following cycle.
- Frame length exactly 10 x BAUD_DIV clocks.
- Simultaneous FIFO push and pop: both honoured; full FIFO with pop + push accepts push (no overflow); empty FIFO pop ignored.
- Same-cycle sticky set and W1C clear of same bit: set wins.
- BAUD_DIV write mid-frame: TX uses new value from next frame; RX uses new value from next frame.
- Reset mid-frame: uart_tx high next cycle, both FSMs IDLE, FIFOs emptied, stickies and IRQ_EN cleared, BAUD_DIV = DEFAULT_DIV.

## Structure
- Package uart_ctrl_pkg: register offset constants, STATUS bit positions, IRQ_EN bit positions, enum uart_state_t {IDLE, START, DATA, STOP} shared by TX and RX FSMs.
- Sub-module sync_fifo #(WIDTH, DEPTH): read-first head output, simultaneous read/write, slots_free and not_empty outputs; instantiated twice (TX, RX).
- TX/RX FSMs, baud counters, synchroniser and register file inline in uart_ctrl.

## Test plan
- Reset, read all four registers -> DATA 0xFFFFFFFF, STATUS 0x0002_0000|FIFO_DEPTH, BAUD_DIV DEFAULT_DIV, IRQ_EN 0; uart_tx 1.
- BAUD_DIV=8, write DATA 0x55 -> uart_tx low 8 clocks, bits 1,0,1,0,1,0,1,0 at 8 clocks each, stop high; frame 80 clocks; TX idle set after.
- Loop uart_tx to uart_rx, BAUD_DIV=8, write 0xA5, 0x3C -> DATA reads 0xA5, 0x3C, then 0xFFFFFFFF.
- Write FIFO_DEPTH+2 bytes with BAUD_DIV=1000 -> first popped into shifter, FIFO full, last byte dropped, STATUS[19]=1; write 0x0008_0000 to STATUS -> bit clears.
- Drive frame with stop bit 0 -> no RX push, FRAME_ERR=1; IRQ_EN=4 -> irq rises 1 cycle after flag.
- BAUD_DIV write 2 -> reads back 4; reset asserted mid-TX frame -> uart_tx 1 next cycle, STATUS slots = FIFO_DEPTH.
